node_idx_reverse_mapper: RTL
============================

Name: node_idx_reverse_mapper

Overview:
- Inverse of the node string-to-index mapping stage: records every (index, packed node string) assignment as it is made.
- Serves index queries by streaming the 3-letter ASCII node name plus newline on a byte stream.
- Sits after the node ID mapping stage, alongside the path solver. Used for result/debug dumps over the UART byte path.

Parameters:
- NODE_STR_WIDTH, 15, packed node string width: three 5-bit letter fields; fixed, do not override.
- MAX_NODES, 1024, table depth.
- NODE_IDX_WIDTH, $clog2(MAX_NODES), index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reg_valid  in  1  registration strobe, one entry per cycle
- reg_node_idx  in  NODE_IDX_WIDTH  index being assigned
- reg_node_str  in  NODE_STR_WIDTH  packed string: [4:0]=char0, [9:5]=char1, [14:10]=char2; each field is letter minus 8'h61
- query_valid  in  1  query request
- query_ready  out  1  query accept
- query_idx  in  NODE_IDX_WIDTH  index to translate
- char_valid  out  1  output byte valid
- char_ready  in  1  downstream accept
- char_data  out  8  ASCII byte
- char_last  out  1  marks the newline byte
- lookup_miss  out  1  one-cycle pulse: the query hit an unassigned index
- node_cnt  out  NODE_IDX_WIDTH+1  number of distinct indices registered

Behaviour:
- Reset (async assert, sync-release-safe):
  - All assigned bits clear; node_cnt=0; FSM=IDLE.
  - query_ready=1, char_valid=0, char_data=0, char_last=0, lookup_miss=0.
  - String RAM contents are not reset.
- Registration: on reg_valid, str_ram[reg_node_idx] <= reg_node_str and assigned[reg_node_idx] <= 1.
  - node_cnt increments only if the index was previously unassigned.
  - Re-registering an index overwrites the string; last write wins, no count change.
  - Registration is accepted in every FSM state and never stalls.
- FSM states: IDLE, LOOKUP, EMIT.
  - IDLE: query_ready=1. On query_valid, latch query_idx and go to LOOKUP.
  - LOOKUP: one cycle of synchronous RAM read plus assigned-bit read; query_ready=0.
    - Bypass: if reg_valid with reg_node_idx == latched index in this cycle, use reg_node_str and treat the entry as assigned.
    - Go to EMIT with char counter = 0.
  - EMIT: char_valid=1; counter 0..3 selects char0, char1, char2, 8'h0A.
    - char_last=1 only at counter 3.
    - Counter advances on char_valid && char_ready.
    - After the handshake at counter 3, go to IDLE.
- Character encoding:
  - Byte = {3'b000, field} + 8'h61 when field <= 25.
  - Field 26..31 emits 8'h3F ('?').
  - Unassigned index emits "???\n" and pulses lookup_miss in the LOOKUP cycle.
- Latency and handshake:
  - Query accepted at cycle T; LOOKUP at T+1; first char_valid at T+2.
  - With char_ready held high, four bytes take T+2..T+5; query_ready=1 again at T+6.
  - char_data and char_last hold stable while char_valid && !char_ready. char_valid never drops before its handshake.
- Boundaries:
  - query_idx >= MAX_NODES: not possible at the default width. With a non-power-of-2 MAX_NODES, an out-of-range query is treated as a miss.
  - node_cnt saturates at MAX_NODES.
  - Reset mid-EMIT aborts the stream immediately (char_valid=0); no partial completion.
  - Registration that changes an entry after LOOKUP does not affect bytes already selected for the current query.

Test Plan:
- Register idx 0 = "you" (fields y=24, o=14, u=20), query 0 with char_ready=1 -> bytes 0x79 0x6F 0x75 0x0A on T+2..T+5; char_last only on 0x0A; node_cnt=1.
- Query unassigned idx 5 -> "???\n" (0x3F 0x3F 0x3F 0x0A); lookup_miss pulses once at T+1.
- Register idx 3 = "out" in the same cycle idx 3 is in LOOKUP -> bypass emits 0x6F 0x75 0x74 0x0A, no miss.
- Stream "svr", toggle char_ready 1/0 every other cycle -> bytes held stable while stalled; query_ready stays 0 until the newline is accepted.
- Register idx 7 twice ("aaa" then "zzz") -> node_cnt=1; query returns 0x7A 0x7A 0x7A 0x0A. Field value 27 in char1 -> byte 0x3F.
- Assert rst_n low during the second byte -> char_valid=0 at once. After release, query 0 -> miss, node_cnt=0.

Source files
------------

// File: rtl/node_idx_reverse_mapper.sv
// Reverse node map: records (index, packed string) assignments and streams the
// 3-letter ASCII name plus newline for an index query.
module node_idx_reverse_mapper #(
  parameter int unsigned NODE_STR_WIDTH = 15,
  parameter int unsigned MAX_NODES      = 1024,
  parameter int unsigned NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reg_valid,
  input  logic [NODE_IDX_WIDTH-1:0] reg_node_idx,
  input  logic [NODE_STR_WIDTH-1:0] reg_node_str,
  input  logic                      query_valid,
  output logic                      query_ready,
  input  logic [NODE_IDX_WIDTH-1:0] query_idx,
  output logic                      char_valid,
  input  logic                      char_ready,
  output logic [7:0]                char_data,
  output logic                      char_last,
  output logic                      lookup_miss,
  output logic [NODE_IDX_WIDTH:0]   node_cnt
);

  localparam int unsigned CNT_W = NODE_IDX_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_t;

  state_t                    state_q, state_d;
  logic [NODE_IDX_WIDTH-1:0] qidx_q, qidx_d;
  logic [NODE_STR_WIDTH-1:0] str_q, str_d;
  logic                      hit_q, hit_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      query_ready_q, query_ready_d;
  logic                      char_valid_q, char_valid_d;
  logic [7:0]                char_data_q, char_data_d;
  logic                      char_last_q, char_last_d;
  logic [MAX_NODES-1:0]      assigned_q;
  logic [CNT_W-1:0]          node_cnt_q;
  logic [NODE_STR_WIDTH-1:0] str_ram [MAX_NODES];

  logic                      reg_in_range, q_in_range, lk_bypass, lk_hit;
  logic [NODE_STR_WIDTH-1:0] lk_str;

  // Letter field to ASCII; codes past 'z' render as '?'.
  function automatic logic [7:0] enc(input logic [4:0] f);
    return (f <= 5'd25) ? (8'({3'b000, f}) + 8'h61) : 8'h3F;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [NODE_STR_WIDTH-1:0] s,
                                          input logic hit, input logic [1:0] c);
    logic [7:0] b;
    case (c)
      2'd0:    b = enc(s[4:0]);
      2'd1:    b = enc(s[9:5]);
      2'd2:    b = enc(s[14:10]);
      default: b = 8'h0A;
    endcase
    if (!hit && c != 2'd3) b = 8'h3F;
    return b;
  endfunction

  assign reg_in_range = {1'b0, reg_node_idx} < CNT_W'(MAX_NODES);
  assign q_in_range   = {1'b0, qidx_q} < CNT_W'(MAX_NODES);
  // A registration landing on the index under lookup is forwarded directly.
  assign lk_bypass    = reg_valid && reg_in_range && (reg_node_idx == qidx_q);
  assign lk_hit       = q_in_range && (lk_bypass || assigned_q[qidx_q]);
  assign lk_str       = lk_bypass ? reg_node_str : str_ram[qidx_q];

  // String storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (reg_valid && reg_in_range) str_ram[reg_node_idx] <= reg_node_str;
  end

  // Assigned bitmap and saturating distinct-index count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assigned_q <= '0;
      node_cnt_q <= '0;
    end else if (reg_valid && reg_in_range) begin
      assigned_q[reg_node_idx] <= 1'b1;
      if (!assigned_q[reg_node_idx] && node_cnt_q < CNT_W'(MAX_NODES))
        node_cnt_q <= node_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      qidx_q        <= '0;
      str_q         <= '0;
      hit_q         <= 1'b0;
      cnt_q         <= 2'd0;
      query_ready_q <= 1'b1;
      char_valid_q  <= 1'b0;
      char_data_q   <= 8'h00;
      char_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      qidx_q        <= qidx_d;
      str_q         <= str_d;
      hit_q         <= hit_d;
      cnt_q         <= cnt_d;
      query_ready_q <= query_ready_d;
      char_valid_q  <= char_valid_d;
      char_data_q   <= char_data_d;
      char_last_q   <= char_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    qidx_d       = qidx_q;
    str_d        = str_q;
    hit_d        = hit_q;
    cnt_d        = cnt_q;
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    char_last_d  = char_last_q;
    case (state_q)
      IDLE: begin
        if (query_valid) begin
          qidx_d  = query_idx;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // Snapshot the entry so later registrations cannot alter this stream.
        str_d        = lk_str;
        hit_d        = lk_hit;
        cnt_d        = 2'd0;
        char_valid_d = 1'b1;
        char_data_d  = sel_byte(lk_str, lk_hit, 2'd0);
        char_last_d  = 1'b0;
        state_d      = EMIT;
      end
      EMIT: begin
        if (char_ready) begin
          if (cnt_q == 2'd3) begin
            char_valid_d = 1'b0;
            char_data_d  = 8'h00;
            char_last_d  = 1'b0;
            state_d      = IDLE;
          end else begin
            cnt_d       = 2'(cnt_q + 2'd1);
            char_data_d = sel_byte(str_q, hit_q, 2'(cnt_q + 2'd1));
            char_last_d = (cnt_q == 2'd2);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign query_ready_d = (state_d == IDLE);

  assign query_ready = query_ready_q;
  assign char_valid  = char_valid_q;
  assign char_data   = char_data_q;
  assign char_last   = char_last_q;
  assign node_cnt    = node_cnt_q;
  assign lookup_miss = (state_q == LOOKUP) && !lk_hit;

endmodule
